fila_resultados: RTL and testbench

Result collection buffer that sits directly downstream of the polynomial evaluator `projeto`. It captures each `Resultado`/`overflow` pair when `pronto` rises and stores it in a small first-word-fall-through FIFO. It presents the stored results to a consumer through a valid/read handshake. It also keeps running statistics: dropped results, overflowed results, and the largest valid result seen.

---
 rtl/fila_resultados.sv | 80 ++++++++
 tb/tb_fila_resultados.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fila_resultados.sv
// fila_resultados: result collection buffer placed after the polynomial
// evaluator. Captures one Resultado/overflow pair per rising edge of pronto
// into a first-word-fall-through FIFO, serves it through a valid/read
// handshake and keeps drop, overflow and maximum statistics.
module fila_resultados #(
   parameter int LARGURA      = 16,
   parameter int PROFUNDIDADE = 4
) (
   input  logic                              ck,
   input  logic                              rst,
   input  logic                              pronto,
   input  logic [LARGURA-1:0]                resultado,
   input  logic                              overflow,
   input  logic                              lido,
   output logic [LARGURA-1:0]                saida,
   output logic                              saida_ovf,
   output logic                              valido,
   output logic                              cheia,
   output logic [$clog2(PROFUNDIDADE+1)-1:0] contagem,
   output logic [7:0]                        descartados,
   output logic [7:0]                        qtd_ovf,
   output logic [LARGURA-1:0]                maximo
);

   localparam int PW = $clog2(PROFUNDIDADE);
   localparam int CW = $clog2(PROFUNDIDADE+1);

   // Saturating 8-bit increment shared by both statistics counters.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic               pronto_ant;
   logic [PW-1:0]      pe;
   logic [PW-1:0]      pl;
   logic [LARGURA:0]   mem [PROFUNDIDADE];

   logic captura;
   logic pop;
   logic push;

   assign valido  = (contagem != '0);
   assign cheia   = (contagem == CW'(PROFUNDIDADE));
   assign captura = pronto & ~pronto_ant;
   assign pop     = lido & valido;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push    = captura & (~cheia | pop);

   // Head entry is presented directly; forced to zero so stale memory never shows.
   assign saida     = valido ? mem[pl][LARGURA-1:0] : '0;
   assign saida_ovf = valido ? mem[pl][LARGURA]     : 1'b0;

   // Control state: edge detector, pointers, occupancy and statistics.
   always_ff @(posedge ck) begin
      if (rst) begin
         pronto_ant  <= 1'b0;
         pe          <= '0;
         pl          <= '0;
         contagem    <= '0;
         descartados <= '0;
         qtd_ovf     <= '0;
         maximo      <= '0;
      end else begin
         pronto_ant <= pronto;
         if (push) pe <= pe + 1'b1;
         if (pop)  pl <= pl + 1'b1;
         if (push && !pop)      contagem <= contagem + 1'b1;
         else if (pop && !push) contagem <= contagem - 1'b1;
         if (captura && !push)    descartados <= sat_inc(descartados);
         if (captura && overflow) qtd_ovf     <= sat_inc(qtd_ovf);
         if (push && !overflow && (resultado > maximo)) maximo <= resultado;
      end
   end

   // Storage array: data only, no reset; empty-forcing masks its contents.
   always_ff @(posedge ck) begin
      if (!rst && push) mem[pe] <= {overflow, resultado};
   end

endmodule

// File: tb/tb_fila_resultados.sv
// Self-checking bench for fila_resultados: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_fila_resultados;

   localparam int W = 16;
   localparam int D = 4;

   logic          ck = 1'b0;
   logic          rst, pronto, overflow, lido;
   logic [W-1:0]  resultado;
   logic [W-1:0]  saida;
   logic          saida_ovf, valido, cheia;
   logic [2:0]    contagem;
   logic [7:0]    descartados, qtd_ovf;
   logic [W-1:0]  maximo;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [W:0]    q[$];
   logic          m_prev;
   int            m_drop, m_ovf;
   logic [W-1:0]  m_max;

   fila_resultados #(.LARGURA(W), .PROFUNDIDADE(D)) dut (
      .ck(ck), .rst(rst), .pronto(pronto), .resultado(resultado),
      .overflow(overflow), .lido(lido), .saida(saida), .saida_ovf(saida_ovf),
      .valido(valido), .cheia(cheia), .contagem(contagem),
      .descartados(descartados), .qtd_ovf(qtd_ovf), .maximo(maximo)
   );

   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, sample at +1.
   task automatic step(input logic r, input logic p, input logic [W-1:0] v,
                       input logic o, input logic l);
      logic cap, pm, full;
      rst = r; pronto = p; resultado = v; overflow = o; lido = l;
      @(posedge ck);
      if (r) begin
         q.delete(); m_prev = 1'b0; m_drop = 0; m_ovf = 0; m_max = '0;
      end else begin
         cap = p && !m_prev;
         m_prev = p;
         full = (q.size() == D);
         pm = l && (q.size() > 0);
         if (cap && o && m_ovf < 255) m_ovf++;
         if (pm) void'(q.pop_front());
         if (cap) begin
            if (!full || pm) begin
               q.push_back({o, v});
               if (!o && v > m_max) m_max = v;
            end else if (m_drop < 255) m_drop++;
         end
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [W:0] h;
      h = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".saida"},       32'(saida),       32'(h[W-1:0]));
      chk({tag, ".saida_ovf"},   32'(saida_ovf),   32'(h[W]));
      chk({tag, ".valido"},      32'(valido),      32'(q.size() > 0));
      chk({tag, ".cheia"},       32'(cheia),       32'(q.size() == D));
      chk({tag, ".contagem"},    32'(contagem),    32'(q.size()));
      chk({tag, ".descartados"}, 32'(descartados), 32'(m_drop));
      chk({tag, ".qtd_ovf"},     32'(qtd_ovf),     32'(m_ovf));
      chk({tag, ".maximo"},      32'(maximo),      32'(m_max));
   endtask

   // One isolated pronto pulse followed by a low cycle.
   task automatic pulse(input logic [W-1:0] v, input logic o);
      step(1'b0, 1'b1, v, o, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      m_prev = 1'b0; m_drop = 0; m_ovf = 0; m_max = '0;

      // reset
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check_model("reset");
      chk("reset.valido_const", 32'(valido), 32'd0);

      // single capture with pronto held 5 cycles
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h7F97, 1'b0, 1'b0);
      check_model("single");
      chk("single.contagem_const", 32'(contagem), 32'd1);
      chk("single.saida_const",    32'(saida),    32'h7F97);
      chk("single.maximo_const",   32'(maximo),   32'h7F97);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("single.read_valido", 32'(valido), 32'd0);
      chk("single.read_saida",  32'(saida),  32'd0);
      check_model("single_read");

      // fill and drop
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) pulse(W'(i), 1'b0);
      check_model("fill");
      chk("fill.cheia_const",       32'(cheia),       32'd1);
      chk("fill.contagem_const",    32'(contagem),    32'd4);
      chk("fill.descartados_const", 32'(descartados), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("fill.read_order", 32'(saida), 32'(i));
         step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      end
      chk("fill.maximo_const", 32'(maximo), 32'd4);
      check_model("fill_drained");

      // full with simultaneous capture and read (pointer wrap)
      for (int i = 10; i <= 13; i++) pulse(W'(i), 1'b0);
      step(1'b0, 1'b1, 16'd14, 1'b0, 1'b1);
      chk("simul.contagem_const",    32'(contagem),    32'd4);
      chk("simul.descartados_const", 32'(descartados), 32'd1);
      check_model("simul");
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 11; i <= 14; i++) begin
         chk("simul.read_order", 32'(saida), 32'(i));
         step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      end
      check_model("simul_drained");

      // overflowed result
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      pulse(16'h7F97, 1'b0);
      pulse(16'hFFFF, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("ovf.saida_const",     32'(saida),     32'hFFFF);
      chk("ovf.saida_ovf_const", 32'(saida_ovf), 32'd1);
      chk("ovf.qtd_ovf_const",   32'(qtd_ovf),   32'd1);
      chk("ovf.maximo_const",    32'(maximo),    32'h7F97);
      check_model("ovf");

      // reset mid-operation with coincident pronto rise and read
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pulse(W'(100 + i), 1'b0);
      step(1'b1, 1'b1, 16'h55AA, 1'b1, 1'b1);
      chk("rstmid.contagem_const", 32'(contagem), 32'd0);
      chk("rstmid.qtd_ovf_const",  32'(qtd_ovf),  32'd0);
      chk("rstmid.maximo_const",   32'(maximo),   32'd0);
      check_model("rstmid");
      // pronto already high on the first cycle after reset captures once
      step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
      chk("postrst.contagem_const", 32'(contagem), 32'd1);
      chk("postrst.saida_const",    32'(saida),    32'h1234);
      check_model("postrst");
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // saturation of both counters
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pulse(W'(i + 1), 1'b0);
      for (int i = 0; i < 260; i++) pulse(W'($urandom), 1'b1);
      chk("sat.descartados_const", 32'(descartados), 32'd255);
      chk("sat.qtd_ovf_const",     32'(qtd_ovf),     32'd255);
      check_model("sat");

      // random traffic
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
              W'($urandom), ($urandom_range(0, 99) < 20),
              ($urandom_range(0, 99) < 35));
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
